// File: rtl/ram_arbiter.sv
// Two-port round-robin / fixed-priority arbiter sharing one data RAM between the NBBPU data port and a debug master.
// Latency: a request sampled in IDLE is served the next cycle and acked, with registered rdata, the cycle after.
// Backpressure: requesters hold req until their one-cycle ack; the port being acked is masked for that IDLE cycle.
module ram_arbiter #(
  parameter bit PRIORITY = 1'b0
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_req0,
  input  logic        i_req1,
  input  logic        i_we0,
  input  logic        i_we1,
  input  logic [15:0] i_addr0,
  input  logic [15:0] i_addr1,
  input  logic [15:0] i_wdata0,
  input  logic [15:0] i_wdata1,
  output logic        o_ack0,
  output logic        o_ack1,
  output logic [15:0] o_rdata0,
  output logic [15:0] o_rdata1,
  output logic        o_ram_we,
  output logic [15:0] o_ram_address,
  output logic [15:0] o_ram_write_data,
  input  logic [15:0] i_ram_read_data,
  output logic        o_busy,
  output logic [15:0] o_contention
);

  typedef enum logic [1:0] {IDLE, SERVE0, SERVE1} state_t;

  state_t      r_state;
  logic        r_last;
  logic        r_ack0;
  logic        r_ack1;
  logic [15:0] r_rdata0;
  logic [15:0] r_rdata1;
  logic [15:0] r_contention;

  logic        w_elig0;
  logic        w_elig1;
  logic        w_grant1;
  logic        w_ram_we;
  logic [15:0] w_ram_address;
  logic [15:0] w_ram_write_data;

  // A port whose ack is high this cycle is finishing, so it cannot win again yet.
  assign w_elig0  = i_req0 & ~r_ack0;
  assign w_elig1  = i_req1 & ~r_ack1;
  assign w_grant1 = w_elig1 & (~w_elig0 | (~PRIORITY & ~r_last));

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= IDLE;
      r_last       <= 1'b1;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_rdata0     <= 16'h0000;
      r_rdata1     <= 16'h0000;
      r_contention <= 16'h0000;
    end else begin
      case (r_state)
        IDLE: begin
          r_ack0 <= 1'b0;
          r_ack1 <= 1'b0;
          if (w_elig0 | w_elig1) begin
            r_state <= w_grant1 ? SERVE1 : SERVE0;
          end
          if (w_elig0 & w_elig1) begin
            r_contention <= r_contention + 16'd1;
          end
        end
        SERVE0: begin
          r_ack0  <= 1'b1;
          r_ack1  <= 1'b0;
          if (!i_we0) r_rdata0 <= i_ram_read_data;
          r_last  <= 1'b0;
          r_state <= IDLE;
        end
        SERVE1: begin
          r_ack1  <= 1'b1;
          r_ack0  <= 1'b0;
          if (!i_we1) r_rdata1 <= i_ram_read_data;
          r_last  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // RAM controls decode straight from state so reset kills a write instantly.
  always_comb begin
    w_ram_we         = 1'b0;
    w_ram_address    = i_addr0;
    w_ram_write_data = i_wdata0;
    case (r_state)
      SERVE0: w_ram_we = i_we0;
      SERVE1: begin
        w_ram_we         = i_we1;
        w_ram_address    = i_addr1;
        w_ram_write_data = i_wdata1;
      end
      default: ;
    endcase
  end

  assign o_ram_we         = w_ram_we;
  assign o_ram_address    = w_ram_address;
  assign o_ram_write_data = w_ram_write_data;
  assign o_ack0           = r_ack0;
  assign o_ack1           = r_ack1;
  assign o_rdata0         = r_rdata0;
  assign o_rdata1         = r_rdata1;
  assign o_busy           = (r_state != IDLE);
  assign o_contention     = r_contention;

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the single data RAM between the NBBPU data port (port 0) and a debug/loader master (port 1). It sits between the requesters and the RAM, serializes accesses with a req/ack handshake, and returns registered read data. Arbitration is round-robin by default; fixed CPU priority is selectable. It also provides a busy flag and a contention counter for debug.

## Interface
- PRIORITY, 0: 0 = round-robin, 1 = port 0 always wins when both request.
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req0, req1  input  1  access request, held until ack.
- we0, we1  input  1  1 = write, 0 = read. Stable while req is high.
- addr0, addr1  input  16  word address. Stable while req is high.
- wdata0, wdata1  input  16  write data. Stable while req is high.
- ack0, ack1  output  1  one-cycle completion pulse, registered.
- rdata0, rdata1  output  16  registered read data. Valid when ack is high; held until the next read completes on that port.
- ram_we  output  1  RAM write enable. Combinational from state.
- ram_address  output  16  RAM address.
- ram_write_data  output  16  RAM write data.
- ram_read_data  input  16  RAM read data, combinational read of ram_address.
- busy  output  1  high when state is not IDLE.
- contention  output  16  count of IDLE-cycle arbitrations where both eligible requests were high.

## Operation
- FSM states: IDLE, SERVE0, SERVE1. Reset state is IDLE.
- IDLE: a port is eligible when req is high and its ack is low in that cycle, so the port being acknowledged is masked.
  - One eligible port: go to SERVEx for that port.
  - Both eligible, PRIORITY=1: go to SERVE0.
  - Both eligible, PRIORITY=0: serve the port opposite the last-served pointer `last`.
  - None eligible: stay in IDLE.
- SERVEx:
  - RAM port muxed from port x: ram_address=addrx, ram_write_data=wdatax, ram_we=wex.
  - At the closing edge: ackx<=1; if wex=0, rdatax<=ram_read_data; last<=x; next state IDLE.
- In IDLE, ram_address=addr0, ram_write_data=wdata0, ram_we=0.
- ack0 and ack1 are high for exactly one cycle, never both in the same cycle.
- contention increments by 1 per qualifying IDLE cycle and wraps 0xFFFF→0x0000. It does not count when only one port is eligible.
- Protocol violation (req dropped during SERVEx) is not checked: the access still completes with whatever inputs are present during SERVE.
- Reset values, applied asynchronously while reset=0:
  - state=IDLE, last=1 (so port 0 wins the first tie).
  - ack0=ack1=0, rdata0=rdata1=0x0000, contention=0, busy=0.
  - ram_we=0 immediately; an in-flight write is aborted without a RAM write edge.

## Timing
- Request high before edge E0 (sampled in IDLE) → SERVE during cycle E0..E1 → ack and rdata valid during E1..E2. Access latency is 2 cycles.
- The RAM write commits at edge E1.
- The requester drops req, or presents a new request, in the ack cycle. A req still high in the ack cycle is ignored for that cycle and re-arbitrated from the next IDLE. Back-to-back accesses from one port run at one per 3 cycles.
- Both ports continuously requesting under round-robin: grants alternate 0,1,0,1 with one SERVE every 2 cycles. The masking makes the IDLE/ack cycle pick the other port.
- busy follows state with no added latency.

## Test plan
- Reset: hold reset=0 with req0=1, we0=1 → ram_we=0, all acks 0, rdata=0x0000, contention=0. After release, the first grant goes to port 0.
- Single write then read, port 0: write addr 0x0010 data 0xBEEF → ram_we high for exactly 1 cycle, ack0 2 cycles after req. Read 0x0010 → rdata0=0xBEEF with ack0.
- Simultaneous requests, PRIORITY=0: req0 (read 0x0010) and req1 (write 0x0020=0x1234) asserted together and held → port 0 is served first, then port 1. contention=1. ack0 and ack1 are never coincident.
- Sustained contention, PRIORITY=1: both requesting for 20 cycles, port 0 re-requesting immediately after ack → port 0 wins every tie. Port 1 is served only in the ack-masked IDLE cycles.
- Async reset mid-write: reset asserted during SERVE1 (we1=1, addr 0x0030=0x5555) → ram_we drops the same cycle and RAM[0x0030] is unchanged. After release the FSM is in IDLE and contention=0.
- Counter wrap: preload via 65535 contended arbitrations, then one more → contention=0x0000.
